// File: rtl/uart_pkg.sv
// uart_pkg: constants and types shared by the UART receive/transmit controllers.
//   UART_DIV_W      - width of the clock-per-bit divisor
//   UART_DATA_W     - width of one UART data byte
//   uart_rx_entry_t - one receive FIFO entry: parity flag plus data byte
package uart_pkg;

    localparam int unsigned UART_DIV_W  = 16;
    localparam int unsigned UART_DATA_W = 8;

    typedef struct packed {
        logic                   perr;
        logic [UART_DATA_W-1:0] data;
    } uart_rx_entry_t;

endpackage

// File: rtl/uart_sync_fifo.sv
// uart_sync_fifo: single-clock FIFO with wrap-bit pointers.
// Ports:
//   clk, rstn    - clock, asynchronous active-low reset
//   push, wdata  - write request and data; accepted when not full, or when full with a
//                  same-cycle accepted pop
//   pop          - read request; ignored when empty
//   rdata        - head entry (combinational)
//   full, empty  - occupancy flags
module uart_sync_fifo #(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic             push,
    input  logic [WIDTH-1:0] wdata,
    input  logic             pop,
    output logic [WIDTH-1:0] rdata,
    output logic             full,
    output logic             empty
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam logic [AW:0] PTR_ONE = 1;

    logic [AW:0]      wptr_q, wptr_d;
    logic [AW:0]      rptr_q, rptr_d;
    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] mem_d [DEPTH];
    logic             push_ok;
    logic             pop_ok;

    // Wrap bits differ with equal index bits: writer is a full lap ahead.
    assign full    = (wptr_q[AW] != rptr_q[AW]) && (wptr_q[AW-1:0] == rptr_q[AW-1:0]);
    assign empty   = (wptr_q == rptr_q);
    assign pop_ok  = pop && !empty;
    assign push_ok = push && (!full || pop_ok);
    assign rdata   = mem_q[rptr_q[AW-1:0]];

    always_comb begin
        mem_d  = mem_q;
        wptr_d = wptr_q;
        rptr_d = rptr_q;
        if (push_ok) begin
            mem_d[wptr_q[AW-1:0]] = wdata;
            wptr_d                = wptr_q + PTR_ONE;
        end
        if (pop_ok) begin
            rptr_d = rptr_q + PTR_ONE;
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            wptr_q <= '0;
            rptr_q <= '0;
            for (int i = 0; i < int'(DEPTH); i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            wptr_q <= wptr_d;
            rptr_q <= rptr_d;
            mem_q  <= mem_d;
        end
    end

endmodule

// File: rtl/uart_rx_ctrl.sv
// uart_rx_ctrl: receive-side controller for the UART receiver datapath.
// Ports:
//   clk, rstn        - clock, asynchronous active-low reset
//   div              - clk cycles per bit (4..65535), latched while rx_br_en is low
//   rx_br_en         - receiver requests bit strobes for the whole frame
//   rx_busy          - receiver not idle; its falling edge marks end of frame
//   rx_dout          - received byte, valid when rx_busy falls
//   rx_parity_err    - parity flag, valid when rx_busy falls
//   rx_br_stb        - registered one-cycle bit strobe, first one at mid start bit
//   m_valid/m_ready  - host stream handshake on the receive FIFO
//   m_data, m_perr   - head entry byte and parity flag
//   ovr, ovr_clr     - sticky overrun flag and its clear
//   to_irq           - registered idle-timeout interrupt level
module uart_rx_ctrl
    import uart_pkg::*;
#(
    parameter int unsigned FIFO_DEPTH = 4,
    parameter logic [31:0] TO_CYC     = 32'd10000
) (
    input  logic                   clk,
    input  logic                   rstn,
    input  logic [UART_DIV_W-1:0]  div,
    input  logic                   rx_br_en,
    input  logic                   rx_busy,
    input  logic [UART_DATA_W-1:0] rx_dout,
    input  logic                   rx_parity_err,
    output logic                   rx_br_stb,
    output logic                   m_valid,
    input  logic                   m_ready,
    output logic [UART_DATA_W-1:0] m_data,
    output logic                   m_perr,
    output logic                   ovr,
    input  logic                   ovr_clr,
    output logic                   to_irq
);

    localparam logic [UART_DIV_W-1:0] BCNT_ONE = 1;

    logic [UART_DIV_W-1:0] bcnt_q, bcnt_d;
    logic [UART_DIV_W-1:0] div_q, div_d;
    logic                  stb_q, stb_d;
    logic                  busy_q, busy_d;
    logic                  ovr_q, ovr_d;
    logic [31:0]           tcnt_q, tcnt_d;
    logic                  irq_q, irq_d;

    logic                  frame_push;
    logic                  pop;
    logic                  fifo_full;
    logic                  fifo_empty;
    logic                  tcnt_clr;
    uart_rx_entry_t        push_entry;
    uart_rx_entry_t        head_entry;

    // busy_q resets to 0, so a frame cut short by reset can never produce a push.
    assign frame_push = busy_q && !rx_busy;
    assign pop        = m_valid && m_ready;
    assign push_entry = '{perr: rx_parity_err, data: rx_dout};

    uart_sync_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH ($bits(uart_rx_entry_t))
    ) u_fifo (
        .clk   (clk),
        .rstn  (rstn),
        .push  (frame_push),
        .wdata (push_entry),
        .pop   (pop),
        .rdata (head_entry),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    assign m_valid   = !fifo_empty;
    assign m_data    = head_entry.data;
    assign m_perr    = head_entry.perr;
    assign rx_br_stb = stb_q;
    assign ovr       = ovr_q;
    assign to_irq    = irq_q;

    // Bit-rate strobe: preload half a bit so the first strobe lands mid start bit.
    always_comb begin
        bcnt_d = bcnt_q;
        div_d  = div_q;
        stb_d  = 1'b0;
        if (!rx_br_en) begin
            bcnt_d = {1'b0, div[UART_DIV_W-1:1]};
            div_d  = div;
        end else if (bcnt_q == BCNT_ONE) begin
            stb_d  = 1'b1;
            bcnt_d = div_q;
        end else begin
            bcnt_d = bcnt_q - BCNT_ONE;
        end
    end

    assign busy_d = rx_busy;

    // A drop happens only when full with no pop; set beats a same-cycle clear.
    always_comb begin
        ovr_d = ovr_q;
        if (frame_push && fifo_full && !pop) begin
            ovr_d = 1'b1;
        end else if (ovr_clr) begin
            ovr_d = 1'b0;
        end
    end

    // Idle timeout: counts only while data waits unread and the link is quiet.
    always_comb begin
        tcnt_clr = frame_push || pop || rx_busy;
        tcnt_d   = tcnt_q;
        if (tcnt_clr) begin
            tcnt_d = '0;
        end else if (m_valid && (tcnt_q != TO_CYC)) begin
            tcnt_d = tcnt_q + 32'd1;
        end
        irq_d = (tcnt_d == TO_CYC) && m_valid && !tcnt_clr;
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            bcnt_q <= '0;
            div_q  <= '0;
            stb_q  <= 1'b0;
            busy_q <= 1'b0;
            ovr_q  <= 1'b0;
            tcnt_q <= '0;
            irq_q  <= 1'b0;
        end else begin
            bcnt_q <= bcnt_d;
            div_q  <= div_d;
            stb_q  <= stb_d;
            busy_q <= busy_d;
            ovr_q  <= ovr_d;
            tcnt_q <= tcnt_d;
            irq_q  <= irq_d;
        end
    end

endmodule

// File: tb/tb_uart_rx_ctrl.sv
// tb_uart_rx_ctrl: self-checking bench for uart_rx_ctrl. A negedge monitor keeps a
// queue of expected FIFO entries and the expected overrun flag; directed sequences
// cover the strobe generator, overrun, simultaneous push/pop, timeout and reset.
module tb_uart_rx_ctrl;

    localparam int unsigned TB_DEPTH  = 4;
    localparam int          TB_TO_CYC = 100;

    logic        clk;
    logic        rstn;
    logic [15:0] div;
    logic        rx_br_en;
    logic        rx_busy;
    logic [7:0]  rx_dout;
    logic        rx_parity_err;
    logic        rx_br_stb;
    logic        m_valid;
    logic        m_ready;
    logic [7:0]  m_data;
    logic        m_perr;
    logic        ovr;
    logic        ovr_clr;
    logic        to_irq;

    int          n_checks;
    int          n_errors;
    int          cyc;

    logic [8:0]  sb[$];
    logic [8:0]  mon_head;
    logic        mon_busy_prev;
    logic        mon_push;
    logic        mon_drop;
    logic        exp_ovr;
    int          valid_cycles;
    int          n_popped;

    uart_rx_ctrl #(
        .FIFO_DEPTH (TB_DEPTH),
        .TO_CYC     (32'(TB_TO_CYC))
    ) dut (
        .clk           (clk),
        .rstn          (rstn),
        .div           (div),
        .rx_br_en      (rx_br_en),
        .rx_busy       (rx_busy),
        .rx_dout       (rx_dout),
        .rx_parity_err (rx_parity_err),
        .rx_br_stb     (rx_br_stb),
        .m_valid       (m_valid),
        .m_ready       (m_ready),
        .m_data        (m_data),
        .m_perr        (m_perr),
        .ovr           (ovr),
        .ovr_clr       (ovr_clr),
        .to_irq        (to_irq)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Scoreboard: model the FIFO from the stimulus and compare every cycle.
    always @(negedge clk) begin
        if (!rstn) begin
            sb.delete();
            mon_busy_prev = 1'b0;
            exp_ovr       = 1'b0;
        end else begin
            check_val("m_valid", 32'(m_valid), 32'(sb.size() > 0));
            check_val("ovr", 32'(ovr), 32'(exp_ovr));
            if (m_valid) valid_cycles++;
            if ((sb.size() > 0) && m_ready) begin
                mon_head = sb.pop_front();
                check_val("m_data", 32'(m_data), 32'(mon_head[7:0]));
                check_val("m_perr", 32'(m_perr), 32'(mon_head[8]));
                n_popped++;
            end
            mon_push      = mon_busy_prev && !rx_busy;
            mon_busy_prev = rx_busy;
            mon_drop      = 1'b0;
            if (mon_push) begin
                if (sb.size() < int'(TB_DEPTH)) sb.push_back({rx_parity_err, rx_dout});
                else mon_drop = 1'b1;
            end
            if (mon_drop) exp_ovr = 1'b1;
            else if (ovr_clr) exp_ovr = 1'b0;
        end
    end

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    // One frame: busy for a few cycles, then present data as rx_busy falls.
    task automatic send_frame(input logic [7:0] d, input logic pe, input logic rdy_on_fall,
                              output int fall_cyc);
        next_cycle();
        rx_busy  = 1'b1;
        rx_br_en = 1'b1;
        repeat (4) next_cycle();
        rx_dout       = d;
        rx_parity_err = pe;
        rx_busy       = 1'b0;
        rx_br_en      = 1'b0;
        if (rdy_on_fall) m_ready = 1'b1;
        fall_cyc = cyc;
        next_cycle();
        if (rdy_on_fall) m_ready = 1'b0;
    endtask

    task automatic run_strobe(input logic [15:0] dv, input int ncyc, input int exp_cnt);
        int exp_q[$];
        int seen;
        rx_br_en = 1'b0;
        div      = dv;
        next_cycle();
        next_cycle();
        for (int k = 0; (int'(dv) / 2) + k * int'(dv) < ncyc; k++) begin
            exp_q.push_back((int'(dv) / 2) + k * int'(dv));
        end
        seen     = 0;
        rx_br_en = 1'b1;
        for (int r = 0; r < ncyc; r++) begin
            @(negedge clk);
            if (rx_br_stb) begin
                seen++;
                if (exp_q.size() == 0) check_val("stb_extra", 32'(r), 32'hffff_ffff);
                else check_val("stb_cycle", 32'(r), 32'(exp_q.pop_front()));
            end
            next_cycle();
        end
        rx_br_en = 1'b0;
        for (int r = 0; r < 12; r++) begin
            @(negedge clk);
            if (rx_br_stb) begin
                seen++;
                check_val("stb_after_en", 32'(rx_br_stb), 32'd0);
            end
            next_cycle();
        end
        check_val("stb_count", 32'(seen), 32'(exp_cnt));
    endtask

    initial begin
        int fall_c;
        int rise_c;
        logic found;

        n_checks      = 0;
        n_errors      = 0;
        cyc           = 0;
        valid_cycles  = 0;
        n_popped      = 0;
        mon_busy_prev = 1'b0;
        exp_ovr       = 1'b0;
        rstn          = 1'b0;
        div           = 16'd16;
        rx_br_en      = 1'b0;
        rx_busy       = 1'b0;
        rx_dout       = 8'h00;
        rx_parity_err = 1'b0;
        m_ready       = 1'b0;
        ovr_clr       = 1'b0;

        repeat (3) next_cycle();
        check_val("rst_stb", 32'(rx_br_stb), 32'd0);
        check_val("rst_m_valid", 32'(m_valid), 32'd0);
        check_val("rst_m_data", 32'(m_data), 32'd0);
        check_val("rst_m_perr", 32'(m_perr), 32'd0);
        check_val("rst_ovr", 32'(ovr), 32'd0);
        check_val("rst_to_irq", 32'(to_irq), 32'd0);
        rstn = 1'b1;
        repeat (2) next_cycle();

        // Strobe generator: nominal, odd divisor, aborted before first strobe.
        run_strobe(16'd16, 160, 10);
        run_strobe(16'd5, 11, 2);
        run_strobe(16'd10, 3, 0);

        // Single frame with host ready: one-cycle m_valid pulse.
        m_ready      = 1'b1;
        valid_cycles = 0;
        send_frame(8'hA5, 1'b0, 1'b0, fall_c);
        repeat (3) next_cycle();
        check_val("single_valid_cycles", 32'(valid_cycles), 32'd1);
        check_val("single_popped", 32'(n_popped), 32'd1);

        // Overrun: five frames into a four-entry FIFO, then clear.
        m_ready = 1'b0;
        for (int i = 1; i <= 5; i++) begin
            send_frame(8'(i * 8'h11), 1'(i % 2), 1'b0, fall_c);
        end
        next_cycle();
        check_val("ovr_set", 32'(ovr), 32'd1);
        ovr_clr = 1'b1;
        next_cycle();
        ovr_clr = 1'b0;
        check_val("ovr_cleared", 32'(ovr), 32'd0);

        // Full FIFO: push and pop in the same cycle, then drain.
        n_popped = 0;
        send_frame(8'h66, 1'b1, 1'b1, fall_c);
        next_cycle();
        check_val("simul_ovr", 32'(ovr), 32'd0);
        m_ready = 1'b1;
        repeat (6) next_cycle();
        m_ready = 1'b0;
        check_val("simul_popped", 32'(n_popped), 32'd5);

        // Idle timeout with one unread byte.
        send_frame(8'h5A, 1'b1, 1'b0, fall_c);
        found  = 1'b0;
        rise_c = 0;
        for (int i = 0; i < 400 && !found; i++) begin
            @(negedge clk);
            if (to_irq) begin
                found  = 1'b1;
                rise_c = cyc;
            end
            next_cycle();
        end
        check_val("irq_seen", 32'(found), 32'd1);
        check_val("irq_delay", 32'(rise_c - fall_c), 32'(TB_TO_CYC + 1));
        m_ready = 1'b1;
        @(negedge clk);
        check_val("irq_hold_on_pop", 32'(to_irq), 32'd1);
        next_cycle();
        m_ready = 1'b0;
        @(negedge clk);
        check_val("irq_fall", 32'(to_irq), 32'd0);
        next_cycle();

        // Reset mid-frame with two entries held.
        send_frame(8'hC3, 1'b1, 1'b0, fall_c);
        send_frame(8'h81, 1'b0, 1'b0, fall_c);
        rx_busy  = 1'b1;
        rx_br_en = 1'b1;
        repeat (3) next_cycle();
        rstn = 1'b0;
        #1;
        check_val("mid_rst_m_valid", 32'(m_valid), 32'd0);
        check_val("mid_rst_m_data", 32'(m_data), 32'd0);
        check_val("mid_rst_m_perr", 32'(m_perr), 32'd0);
        check_val("mid_rst_ovr", 32'(ovr), 32'd0);
        check_val("mid_rst_to_irq", 32'(to_irq), 32'd0);
        check_val("mid_rst_stb", 32'(rx_br_stb), 32'd0);
        rx_busy  = 1'b0;
        rx_br_en = 1'b0;
        repeat (2) next_cycle();
        rstn = 1'b1;
        repeat (5) next_cycle();
        check_val("post_rst_no_push", 32'(m_valid), 32'd0);
        m_ready  = 1'b1;
        n_popped = 0;
        send_frame(8'h3C, 1'b0, 1'b0, fall_c);
        repeat (3) next_cycle();
        check_val("post_rst_frame", 32'(n_popped), 32'd1);
        check_val("sb_drained", 32'(sb.size()), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not complete, got timeout, expected finish");
        $fatal(1, "watchdog expired");
    end

endmodule
